// File: rtl/spio_hss_multiplexer_reg_master_pkg.sv
// Shared definitions for the HSS multiplexer register bank and its access master:
// bus widths, register map and master FSM state encoding.
package spio_hss_multiplexer_reg_master_pkg;

  localparam int REGA_BITS = 5;
  localparam int REGD_BITS = 32;

  // Register map; addresses between IDSI_REG and RECO_REG are event counters.
  localparam logic [REGA_BITS-1:0] VERS_REG      = 5'd0;
  localparam logic [REGA_BITS-1:0] HAND_REG      = 5'd1;
  localparam logic [REGA_BITS-1:0] IDSO_REG      = 5'd2;
  localparam logic [REGA_BITS-1:0] IDSI_REG      = 5'd3;
  localparam logic [REGA_BITS-1:0] CNT_FIRST_REG = 5'd4;
  localparam logic [REGA_BITS-1:0] CNT_LAST_REG  = 5'd21;
  localparam logic [REGA_BITS-1:0] RECO_REG      = 5'd22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

endpackage

// File: rtl/spio_hss_multiplexer_reg_master.sv
// Register-bank access initiator: single read/write commands plus a sequential
// scan of addresses 0..SCAN_LAST, each result returned over a valid/ready response.
module spio_hss_multiplexer_reg_master
  import spio_hss_multiplexer_reg_master_pkg::*;
#(
  parameter int ADDR_BITS = REGA_BITS,
  parameter int DATA_BITS = REGD_BITS,
  parameter int SCAN_LAST = int'(RECO_REG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_vld,
  output logic                 cmd_rdy,
  input  logic                 cmd_write,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [DATA_BITS-1:0] cmd_wdata,
  input  logic                 scan_start,
  output logic                 scan_busy,
  output logic                 rsp_vld,
  input  logic                 rsp_rdy,
  output logic [ADDR_BITS-1:0] rsp_addr,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 rsp_wr,
  output logic                 rsp_last,
  output logic                 reg_write,
  output logic [ADDR_BITS-1:0] reg_addr,
  output logic [DATA_BITS-1:0] reg_write_data,
  input  logic [DATA_BITS-1:0] reg_read_data
);

  localparam logic [ADDR_BITS-1:0] SCAN_LAST_A = ADDR_BITS'(SCAN_LAST);

  state_t state_reg, state_next;
  logic   scan_pend_reg;
  logic   scan_act_reg;
  logic   cmd_fire;
  logic   scan_more;

  assign cmd_rdy   = (state_reg == ST_IDLE);
  assign rsp_vld   = (state_reg == ST_RSP);
  assign scan_busy = scan_pend_reg | scan_act_reg;
  assign cmd_fire  = cmd_vld & cmd_rdy;
  assign scan_more = scan_act_reg & ~rsp_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (cmd_fire || scan_pend_reg) state_next = ST_ACC;
      ST_ACC:  state_next = ST_RSP;
      ST_RSP:  if (rsp_rdy) state_next = scan_more ? ST_ACC : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_pend_reg  <= 1'b0;
      scan_act_reg   <= 1'b0;
      reg_write      <= 1'b0;
      reg_addr       <= '0;
      reg_write_data <= '0;
      rsp_addr       <= '0;
      rsp_data       <= '0;
      rsp_wr         <= 1'b0;
      rsp_last       <= 1'b0;
    end else begin
      // A request arriving on the launch cycle itself re-arms the pending flag.
      if (scan_start && !scan_act_reg)
        scan_pend_reg <= 1'b1;
      else if (cmd_rdy && !cmd_vld && scan_pend_reg)
        scan_pend_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (cmd_fire) begin
            reg_addr       <= cmd_addr;
            reg_write_data <= cmd_wdata;
            reg_write      <= cmd_write;
          end else if (scan_pend_reg) begin
            reg_addr     <= '0;
            scan_act_reg <= 1'b1;
          end
        end
        ST_ACC: begin
          // The bank commits a write on this same edge, so a write returns the old value.
          rsp_data  <= reg_read_data;
          rsp_addr  <= reg_addr;
          rsp_wr    <= reg_write;
          rsp_last  <= scan_act_reg & (reg_addr == SCAN_LAST_A);
          reg_write <= 1'b0;
        end
        ST_RSP: begin
          if (rsp_rdy) begin
            if (scan_more) reg_addr     <= reg_addr + ADDR_BITS'(1);
            else           scan_act_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/spio_hss_multiplexer_reg_master.md
# spio_hss_multiplexer_reg_master

Register-access initiator for the HSS multiplexer register bank. It accepts single read/write commands over a valid/ready interface and drives the bank's `reg_write`/`reg_addr`/`reg_write_data` port. It captures `reg_read_data` and returns each result over a valid/ready response interface. A scan mode reads addresses 0..`SCAN_LAST` in sequence, so a host bridge or diagnostics streamer can snapshot all counters with one request.

## Interface
- `ADDR_BITS`, default 5: register address width; equals `REGA_BITS`.
- `DATA_BITS`, default 32: register data width; equals `REGD_BITS`.
- `SCAN_LAST`, default 22: last address visited by a scan; set to `RECO_REG`.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_vld` in 1: command valid.
- `cmd_rdy` out 1: command ready; equals (state==IDLE).
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_BITS: target address.
- `cmd_wdata` in DATA_BITS: write data.
- `scan_start` in 1: one-cycle pulse requesting a full scan.
- `scan_busy` out 1: a scan is pending or in progress.
- `rsp_vld` out 1: response valid.
- `rsp_rdy` in 1: response accepted.
- `rsp_addr` out ADDR_BITS: address the response refers to.
- `rsp_data` out DATA_BITS: data read at that address.
- `rsp_wr` out 1: response belongs to a write command.
- `rsp_last` out 1: final response of a scan.
- `reg_write` out 1: bank write strobe.
- `reg_addr` out ADDR_BITS: bank address.
- `reg_write_data` out DATA_BITS: bank write data.
- `reg_read_data` in DATA_BITS: bank read data (combinational from `reg_addr`).

## Operation
- FSM states: IDLE, ACC, RSP.
- **IDLE**
  - `cmd_vld & cmd_rdy`: register `cmd_addr` into `reg_addr` and `cmd_wdata` into `reg_write_data`. Set `reg_write`=`cmd_write`. Go to ACC.
  - Otherwise, if `scan_pend` is set: `reg_addr`←0, clear `scan_pend`, set `scan_act`, go to ACC.
  - A command handshake has priority over a pending scan.
- **ACC** (exactly one cycle)
  - `rsp_data`←`reg_read_data`, `rsp_addr`←`reg_addr`, `rsp_wr`←`reg_write`.
  - `rsp_last`←`scan_act & (reg_addr==SCAN_LAST)`.
  - `reg_write`←0. Go to RSP.
  - For writes, `rsp_data` is the pre-write value, because the bank updates on the ACC→RSP edge.
- **RSP**
  - `rsp_vld`=1; all `rsp_*` outputs hold stable until `rsp_rdy`.
  - On `rsp_rdy`, if `scan_act` and not `rsp_last`: `reg_addr`←`reg_addr`+1, go to ACC.
  - Otherwise: clear `scan_act`, go to IDLE.
- `scan_start` sets `scan_pend` in any state. It is ignored while `scan_act` is already set.
- `scan_busy` = `scan_pend | scan_act`.
- `reg_addr` and `reg_write_data` hold their last values in IDLE. `reg_write` is only ever high in ACC.
- Scan address increment is ADDR_BITS wide. It cannot wrap, because `SCAN_LAST` < 2^ADDR_BITS.
- Unmapped addresses return whatever the bank drives (all-ones); no error flag.

## Timing
- Reset values:
  - state IDLE.
  - `reg_write`=0, `reg_addr`=0, `reg_write_data`=0.
  - `rsp_vld`=0, `rsp_addr`=0, `rsp_data`=0, `rsp_wr`=0, `rsp_last`=0.
  - `scan_pend`=0, `scan_act`=0.
  - `cmd_rdy`=1 immediately after reset deassertion.
- Command latency:
  - Accept at edge N.
  - `reg_write`/`reg_addr` valid in cycle N+1 (ACC).
  - `rsp_vld` from cycle N+2.
  - Minimum 3 cycles per command with `rsp_rdy` tied high.
- Scan: 2 cycles per register with `rsp_rdy` high. A full default scan takes 46 cycles after leaving IDLE.
- Backpressure: `rsp_rdy` low stalls in RSP indefinitely; `cmd_rdy` stays 0 throughout.
- Reset mid-operation: immediate return to IDLE with the values above. No partial write is issued after reset, and the pending scan is dropped.

## Structure
- Shared header (existing common header plus the reg-bank header):
  - `REGA_BITS`, `REGD_BITS`.
  - Register address defines (`VERS_REG`…`RECO_REG`).
  - FSM state encodings.
- Single flat module; no sub-module needed.
- The bench instantiates it against `spio_hss_multiplexer_reg_bank`.

## Test plan
- **Read version:** read `cmd_addr`=`VERS_REG` → one response with `rsp_addr`=`VERS_REG`, `rsp_data` = version word, `rsp_wr`=0, `rsp_vld` in cycle N+2.
- **Write/read-back:** write `IDSO_REG` with 0x0000_00A5 → `reg_write` high for exactly one cycle. Response `rsp_wr`=1 with the old value 0. A following read of `IDSO_REG` returns 0xA5.
- **Scan after reset:** `scan_start` → 23 responses, addresses 0..22 in order. Counters read 0, except `VERS`/`HAND` as driven. `rsp_last`=1 only at address 22. `scan_busy` drops after the last handshake.
- **Backpressure:** hold `rsp_rdy`=0 for 10 cycles mid-scan → `rsp_*` stable, `cmd_rdy`=0, no address advance. The scan resumes on release.
- **Priority:** `cmd_vld` and `scan_start` in the same IDLE cycle → command served first, scan follows. A second `scan_start` during the scan is ignored.
- **Reset mid-operation:** assert `rst` while in ACC with a write → `reg_write`=0 at once, `rsp_vld`=0, `scan_busy`=0, `IDSO` unchanged.
